// File: rtl/xoodyak_seq_pkg.sv
// Shared types and defaults for the Xoodyak command sequencer: command entry
// layout, opmode function codes and the sequencer FSM state encoding.
package xoodyak_seq_pkg;

    localparam int PKG_OP_W   = 5;
    localparam int PKG_TEXT_W = 192;
    localparam int PKG_DATA_W = 352;
    localparam int PKG_SLOT_W = 4;

    // Low four opmode bits; the opmode MSB is the "continue" flag.
    typedef enum logic [3:0] {
        FN_IDLE             = 4'd0,
        FN_KEYED_INIT       = 4'd1,
        FN_ABSORB_AD        = 4'd2,
        FN_ENCRYPT          = 4'd3,
        FN_DECRYPT          = 4'd4,
        FN_SQUEEZE_TAG      = 4'd5,
        FN_SQUEEZE_KEY      = 4'd6,
        FN_NONCE            = 4'd7,
        FN_HASH_INIT        = 4'd8,
        FN_HASH_ABSORB_MORE = 4'd9,
        FN_HASH_ABSORB      = 4'd10,
        FN_AD_MORE          = 4'd11,
        FN_CRYPT_MORE       = 4'd12,
        FN_HASH_SQUEEZE     = 4'd13,
        FN_RATCHET          = 4'd14
    } op_fn_e;

    typedef struct packed {
        logic [PKG_OP_W-1:0]   op;
        logic [PKG_SLOT_W-1:0] slot;
        logic                  chk;
        logic [PKG_TEXT_W-1:0] exp;
    } cmd_entry_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } seq_state_e;

endpackage

// File: rtl/xoodyak_seq_checker.sv
// Per-entry check window: compares the first textout strobe of a checked entry,
// flags a missing strobe at window end, and keeps the sticky error record.
module xoodyak_seq_checker
    import xoodyak_seq_pkg::*;
#(
    parameter int TEXT_W = PKG_TEXT_W,
    parameter int IDX_W  = 6
)(
    input  logic              eph1,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_active,
    input  logic              i_last,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic              i_chk,
    input  logic [TEXT_W-1:0] i_exp,
    input  logic [TEXT_W-1:0] i_text,
    input  logic              i_text_valid,
    output logic              o_mismatch,
    output logic [15:0]       o_err_count,
    output logic [IDX_W-1:0]  o_first_err_idx
);

    logic             r_seen;
    logic             r_mismatch;
    logic [15:0]      r_err_count;
    logic [IDX_W-1:0] r_first_err_idx;

    logic w_hit;
    logic w_bad_cmp;
    logic w_missing;
    logic w_err;

    // Only the first strobe of a window is judged; a strobe on the last cycle
    // still counts as present, so the missing test excludes it.
    assign w_hit     = i_active && i_chk && i_text_valid && !r_seen;
    assign w_bad_cmp = w_hit && (i_text != i_exp);
    assign w_missing = i_active && i_chk && i_last && !r_seen && !i_text_valid;
    assign w_err     = w_bad_cmp || w_missing;

    always_ff @(posedge eph1) begin
        if (reset || i_clear) begin
            r_seen          <= 1'b0;
            r_mismatch      <= 1'b0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
        end else begin
            r_seen <= (i_active && !i_last) ? (r_seen || w_hit) : 1'b0;
            if (w_err) begin
                if (r_err_count != 16'hFFFF) begin
                    r_err_count <= r_err_count + 16'd1;
                end
                r_mismatch <= 1'b1;
                if (!r_mismatch) begin
                    r_first_err_idx <= i_idx;
                end
            end
        end
    end

    assign o_mismatch      = r_mismatch;
    assign o_err_count     = r_err_count;
    assign o_first_err_idx = r_first_err_idx;

endmodule

// File: rtl/xoodyak_cmd_sequencer.sv
// Replays a programmed list of Xoodyak opmode/data commands into the core,
// holding each for HOLD cycles, and checks the core's textout against per-entry expectations.
module xoodyak_cmd_sequencer
    import xoodyak_seq_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int HOLD   = 4,
    parameter int NSLOT  = 9,
    parameter int DATA_W = PKG_DATA_W,
    parameter int TEXT_W = PKG_TEXT_W,
    parameter int OP_W   = PKG_OP_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int SW    = $clog2(NSLOT)
)(
    input  logic              eph1,
    input  logic              reset,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [SW-1:0]     cmd_slot,
    input  logic              cmd_chk,
    input  logic [TEXT_W-1:0] cmd_exp,
    input  logic              slot_we,
    input  logic [SW-1:0]     slot_idx,
    input  logic [DATA_W-1:0] slot_data,
    input  logic              run,
    input  logic              loop,
    input  logic [AW:0]       seq_len,
    input  logic              stop,
    input  logic [TEXT_W-1:0] textout_r,
    input  logic              textout_valid,
    output logic [OP_W-1:0]   opmode,
    output logic [DATA_W-1:0] input_data,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     step_idx,
    output logic              mismatch,
    output logic [15:0]       err_count,
    output logic [AW-1:0]     first_err_idx
);

    localparam int            HW      = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [SW:0]   NSLOT_L = (SW+1)'(NSLOT);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    cmd_entry_t        r_cmd_mem  [DEPTH];
    logic [DATA_W-1:0] r_slot_mem [NSLOT];

    seq_state_e        r_state, w_state_nxt;
    logic [AW-1:0]     r_step, w_step_nxt;
    logic [HW-1:0]     r_hold, w_hold_nxt;
    logic [AW:0]       r_len;
    logic              r_loop;
    logic              r_done, w_done_nxt;
    logic [OP_W-1:0]   r_opmode;
    logic [DATA_W-1:0] r_input_data;
    logic              r_chk;
    logic [TEXT_W-1:0] r_exp;

    logic              w_busy;
    logic              w_start;
    logic              w_last;
    logic              w_final;
    logic              w_cmd_wr;
    logic              w_slot_wr;
    logic              w_slot_ok;
    cmd_entry_t        w_cmd_wdata;
    cmd_entry_t        w_entry;
    logic [DATA_W-1:0] w_slot_rd;

    assign w_busy      = (r_state == S_PLAY);
    assign w_last      = (r_hold == HOLD_LAST);
    assign w_final     = ({1'b0, r_step} == (r_len - (AW+1)'(1)));
    assign w_cmd_wr    = cmd_we && !w_busy;
    assign w_slot_wr   = slot_we && !w_busy && ({1'b0, slot_idx} < NSLOT_L);
    assign w_cmd_wdata = '{op: cmd_op, slot: cmd_slot, chk: cmd_chk, exp: cmd_exp};

    always_ff @(posedge eph1) begin
        // NOTE: the command and slot arrays carry no reset, so they map onto plain
        // storage; a sequence must be loaded before it is meaningful.
        if (w_cmd_wr) begin
            r_cmd_mem[cmd_addr] <= w_cmd_wdata;
        end
        if (w_slot_wr) begin
            r_slot_mem[slot_idx] <= slot_data;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves one unassigned and infers a latch.
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_hold_nxt  = r_hold;
        w_done_nxt  = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run && !stop) begin
                    w_start = 1'b1;
                    if (seq_len != '0) begin
                        w_state_nxt = S_PLAY;
                        w_step_nxt  = '0;
                        w_hold_nxt  = '0;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_step_nxt  = '0;
                    w_hold_nxt  = '0;
                    w_done_nxt  = 1'b1;
                end else if (w_last) begin
                    w_hold_nxt = '0;
                    if (!w_final) begin
                        w_step_nxt = r_step + AW'(1);
                    end else if (r_loop) begin
                        w_step_nxt = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_step_nxt  = '0;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_hold_nxt = r_hold + HW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_step_nxt  = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // Writes accepted in the run cycle bypass the arrays so entry 0 sees them.
    always_comb begin
        w_entry = r_cmd_mem[w_step_nxt];
        if (w_cmd_wr && (cmd_addr == w_step_nxt)) begin
            w_entry = w_cmd_wdata;
        end
        w_slot_ok = ({1'b0, w_entry.slot} < NSLOT_L);
        w_slot_rd = w_slot_ok ? r_slot_mem[w_entry.slot] : '0;
        if (w_slot_wr && (slot_idx == w_entry.slot)) begin
            w_slot_rd = slot_data;
        end
    end

    always_ff @(posedge eph1) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state      <= S_IDLE;
            r_step       <= '0;
            r_hold       <= '0;
            r_len        <= '0;
            r_loop       <= 1'b0;
            r_done       <= 1'b0;
            r_opmode     <= '0;
            r_input_data <= '0;
            r_chk        <= 1'b0;
            r_exp        <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_hold  <= w_hold_nxt;
            r_done  <= w_done_nxt;
            if (w_start) begin
                r_len  <= seq_len;
                r_loop <= loop;
            end
            if (w_state_nxt == S_PLAY) begin
                r_opmode     <= w_entry.op;
                r_input_data <= w_slot_rd;
                r_chk        <= w_entry.chk;
                r_exp        <= w_entry.exp;
            end else begin
                r_opmode     <= '0;
                r_input_data <= '0;
                r_chk        <= 1'b0;
                r_exp        <= '0;
            end
        end
    end

    xoodyak_seq_checker #(
        .TEXT_W (TEXT_W),
        .IDX_W  (AW)
    ) u_checker (
        .eph1            (eph1),
        .reset           (reset),
        .i_clear         (w_start),
        .i_active        (w_busy),
        .i_last          (w_last),
        .i_idx           (r_step),
        .i_chk           (r_chk),
        .i_exp           (r_exp),
        .i_text          (textout_r),
        .i_text_valid    (textout_valid),
        .o_mismatch      (mismatch),
        .o_err_count     (err_count),
        .o_first_err_idx (first_err_idx)
    );

    assign opmode     = r_opmode;
    assign input_data = r_input_data;
    assign busy       = w_busy;
    assign done       = r_done;
    assign step_idx   = r_step;

endmodule

// File: tb/tb_xoodyak_cmd_sequencer.sv
// Self-checking bench for xoodyak_cmd_sequencer: the bench plays the core, and
// expected traces/error counts come from a window-level model of the program.
module tb_xoodyak_cmd_sequencer;

    localparam int HOLD = 4;

    logic         eph1 = 1'b0;
    logic         reset;
    logic         cmd_we;
    logic [5:0]   cmd_addr;
    logic [4:0]   cmd_op;
    logic [3:0]   cmd_slot;
    logic         cmd_chk;
    logic [191:0] cmd_exp;
    logic         slot_we;
    logic [3:0]   slot_idx;
    logic [351:0] slot_data;
    logic         run;
    logic         loop;
    logic [6:0]   seq_len;
    logic         stop;
    logic [191:0] textout_r;
    logic         textout_valid;
    logic [4:0]   opmode;
    logic [351:0] input_data;
    logic         busy;
    logic         done;
    logic [5:0]   step_idx;
    logic         mismatch;
    logic [15:0]  err_count;
    logic [5:0]   first_err_idx;

    xoodyak_cmd_sequencer dut (
        .eph1          (eph1),
        .reset         (reset),
        .cmd_we        (cmd_we),
        .cmd_addr      (cmd_addr),
        .cmd_op        (cmd_op),
        .cmd_slot      (cmd_slot),
        .cmd_chk       (cmd_chk),
        .cmd_exp       (cmd_exp),
        .slot_we       (slot_we),
        .slot_idx      (slot_idx),
        .slot_data     (slot_data),
        .run           (run),
        .loop          (loop),
        .seq_len       (seq_len),
        .stop          (stop),
        .textout_r     (textout_r),
        .textout_valid (textout_valid),
        .opmode        (opmode),
        .input_data    (input_data),
        .busy          (busy),
        .done          (done),
        .step_idx      (step_idx),
        .mismatch      (mismatch),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    always #5 eph1 = ~eph1;

    // Program entry plus the bench-core's textout plan for that entry's window.
    typedef struct {
        logic [4:0]   op;
        logic [3:0]   slot;
        logic         chk;
        logic [191:0] exp;
        int           vc;
        int           vc2;
        logic [191:0] vv;
        logic [191:0] vv2;
    } ent_t;

    typedef struct {
        int vc;
        bit good;
        int vc2;
        bit good2;
        bit chk;
        int cnt;
    } vec_t;

    ent_t         prog  [64];
    logic [351:0] slots [9];
    vec_t         tbl   [9];
    int           total = 0;
    int           bad   = 0;

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge eph1);
        #1;
    endtask

    function automatic logic [191:0] golden(input logic [4:0] op, input logic [351:0] d);
        return d[191:0] ^ d[351:160] ^ {187'd0, op};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) begin
            prog[i].op   = 5'($urandom);
            prog[i].slot = 4'($urandom_range(0, 8));
            prog[i].chk  = 1'b0;
            prog[i].exp  = golden(prog[i].op, slots[prog[i].slot]);
            prog[i].vc   = -1;
            prog[i].vc2  = -1;
            prog[i].vv   = prog[i].exp;
            prog[i].vv2  = '0;
        end
    endtask

    task automatic load(input int len);
        for (int i = 0; i < 9; i++) begin
            slot_we = 1'b1; slot_idx = 4'(i); slot_data = slots[i];
            tick();
        end
        slot_we = 1'b0;
        for (int i = 0; i < len; i++) begin
            cmd_we = 1'b1; cmd_addr = 6'(i); cmd_op = prog[i].op;
            cmd_slot = prog[i].slot; cmd_chk = prog[i].chk; cmd_exp = prog[i].exp;
            tick();
        end
        cmd_we = 1'b0;
    endtask

    // Window-level model: ncyc played cycles split into HOLD-long windows; the
    // last may be cut short by stop, in which case no missing error is raised.
    task automatic model(input int len, input int ncyc, output int cnt, output int first);
        int e, present;
        bit found;
        logic [191:0] v;
        cnt = 0; first = 0;
        for (int w = 0; w * HOLD < ncyc; w++) begin
            e = w % len;
            present = (ncyc - w * HOLD < HOLD) ? ncyc - w * HOLD : HOLD;
            found = 1'b0; v = '0;
            if (prog[e].chk) begin
                for (int h = 0; h < present && !found; h++) begin
                    if (prog[e].vc == h) begin found = 1'b1; v = prog[e].vv; end
                    else if (prog[e].vc2 == h) begin found = 1'b1; v = prog[e].vv2; end
                end
                if (found ? (v != prog[e].exp) : (present == HOLD)) begin
                    if (cnt == 0) first = e;
                    cnt++;
                end
            end
        end
    endtask

    // Plays len entries for ncyc cycles (loop runs end with stop on the last
    // cycle), checking the trace every cycle and the error record at the end.
    // A second run and writes are injected mid-play; both must be ignored.
    task automatic play(input int len, input bit lp, input int ncyc);
        int cnt, first, e, h;
        model(len, ncyc, cnt, first);
        seq_len = 7'(len); loop = lp; run = 1'b1;
        tick();
        run = 1'b0; cmd_we = 1'b0; slot_we = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            e = (c / HOLD) % len;
            h = c % HOLD;
            check("trace", {busy, done, step_idx, opmode}, {1'b1, 1'b0, 6'(e), prog[e].op});
            check("data", input_data, slots[prog[e].slot]);
            textout_valid = (prog[e].vc == h) || (prog[e].vc2 == h);
            textout_r     = (prog[e].vc == h) ? prog[e].vv : prog[e].vv2;
            run     = (c == 1);
            seq_len = 7'($urandom_range(1, 64));
            loop    = ~lp;
            cmd_we  = (c == 2); cmd_addr = 6'(len - 1); cmd_op = ~prog[len-1].op;
            cmd_slot = prog[len-1].slot; cmd_chk = 1'b1; cmd_exp = '0;
            slot_we = (c == 2); slot_idx = prog[len-1].slot; slot_data = ~slots[prog[len-1].slot];
            stop    = lp && (c == ncyc - 1);
            tick();
        end
        textout_valid = 1'b0; run = 1'b0; stop = 1'b0; cmd_we = 1'b0; slot_we = 1'b0;
        check("end_done", {busy, done}, 2'b01);
        check("err_count", err_count, 16'(cnt));
        check("mismatch", mismatch, 1'(cnt != 0));
        check("first_err", first_err_idx, 6'(first));
        tick();
        check("done_clr", {busy, done}, 2'b00);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cmd_we = 1'b0; cmd_addr = '0; cmd_op = '0; cmd_slot = '0;
        cmd_chk = 1'b0; cmd_exp = '0; slot_we = 1'b0; slot_idx = '0; slot_data = '0;
        run = 1'b0; loop = 1'b0; seq_len = '0; stop = 1'b0;
        textout_r = '0; textout_valid = 1'b0;
        for (int i = 0; i < 9; i++) slots[i] = {11{$urandom}};
        repeat (3) tick();
        reset = 1'b0;
        check("rst_state", {opmode, busy, done, step_idx, mismatch, err_count, first_err_idx}, '0);
        check("rst_data", input_data, '0);

        // Basic three-entry play: 12 busy cycles, done on the 13th.
        clear_prog();
        load(3);
        play(3, 1'b0, 12);

        // seq_len = 0 stays idle with a done pulse; run with stop does nothing.
        seq_len = '0; run = 1'b1;
        tick();
        run = 1'b0;
        check("len0_done", {busy, done}, 2'b01);
        tick();
        check("len0_clr", {busy, done}, 2'b00);
        seq_len = 7'd3; run = 1'b1; stop = 1'b1;
        tick();
        run = 1'b0; stop = 1'b0;
        check("run_stop", {busy, done, opmode}, '0);

        // Check-window vectors applied to entry 2 of a three-entry program.
        tbl[0] = '{0,  1'b1, -1, 1'b0, 1'b1, 0};
        tbl[1] = '{3,  1'b1, -1, 1'b0, 1'b1, 0};
        tbl[2] = '{-1, 1'b0, -1, 1'b0, 1'b1, 1};
        tbl[3] = '{1,  1'b0, -1, 1'b0, 1'b1, 1};
        tbl[4] = '{1,  1'b1, 2,  1'b0, 1'b1, 0};
        tbl[5] = '{0,  1'b0, 3,  1'b1, 1'b1, 1};
        tbl[6] = '{2,  1'b0, -1, 1'b0, 1'b0, 0};
        tbl[7] = '{-1, 1'b0, -1, 1'b0, 1'b0, 0};
        tbl[8] = '{-1, 1'b0, 3,  1'b1, 1'b1, 0};
        for (int i = 0; i < 9; i++) begin
            clear_prog();
            prog[2].op  = 5'd13; prog[2].slot = 4'd3; prog[2].chk = tbl[i].chk;
            prog[2].exp = golden(5'd13, slots[3]);
            prog[2].vc  = tbl[i].vc;
            prog[2].vv  = tbl[i].good ? prog[2].exp : prog[2].exp ^ 192'd1;
            prog[2].vc2 = tbl[i].vc2;
            prog[2].vv2 = tbl[i].good2 ? prog[2].exp : prog[2].exp ^ 192'd2;
            load(3);
            play(3, 1'b0, 12);
            check("vec_cnt", err_count, 16'(tbl[i].cnt));
            check("vec_first", first_err_idx, (tbl[i].cnt != 0) ? 6'd2 : 6'd0);
        end

        // Hash sequence with the squeeze checked against the golden output.
        clear_prog();
        prog[0].op = 5'd10; prog[0].slot = 4'd1;
        prog[1].op = 5'd9;  prog[1].slot = 4'd2;
        prog[2].op = 5'd13; prog[2].slot = 4'd3; prog[2].chk = 1'b1;
        prog[2].exp = golden(5'd13, slots[3]);
        prog[2].vc = 1; prog[2].vv = golden(5'd13, slots[3]);
        load(3);
        play(3, 1'b0, 12);
        check("hash_clean", {mismatch, err_count}, '0);

        // Entry 5 expectation off by one bit; error record survives looping.
        clear_prog();
        for (int i = 3; i < 8; i += 2) begin
            prog[i].chk = 1'b1;
            prog[i].vc  = int'($urandom_range(0, 3));
            prog[i].vv  = prog[i].exp;
        end
        prog[5].exp = prog[5].exp ^ (192'd1 << 17);
        load(8);
        play(8, 1'b0, 32);
        check("e5_once", {mismatch, err_count, first_err_idx}, {1'b1, 16'd1, 6'd5});
        play(8, 1'b1, 70);
        check("e5_loop", {mismatch, err_count, first_err_idx}, {1'b1, 16'd2, 6'd5});

        // Two-entry loop for 20 cycles then stop: 0,1,0,1,0.
        clear_prog();
        load(2);
        play(2, 1'b1, 20);

        // Writes landing in the run cycle are used by the sequence.
        clear_prog();
        load(1);
        prog[0].op = ~prog[0].op;
        slots[prog[0].slot] = {11{$urandom}};
        cmd_we = 1'b1; cmd_addr = 6'd0; cmd_op = prog[0].op; cmd_slot = prog[0].slot;
        cmd_chk = 1'b0; cmd_exp = prog[0].exp;
        slot_we = 1'b1; slot_idx = prog[0].slot; slot_data = slots[prog[0].slot];
        play(1, 1'b0, 4);

        // Reset in the middle of entry 3 after a missing error; busy writes dropped.
        clear_prog();
        prog[1].chk = 1'b1;
        load(6);
        seq_len = 7'd6; loop = 1'b0; run = 1'b1;
        tick();
        run = 1'b0;
        for (int c = 0; c < 13; c++) tick();
        check("pre_rst", {busy, step_idx, err_count, first_err_idx}, {1'b1, 6'd3, 16'd1, 6'd1});
        cmd_we = 1'b1; cmd_addr = 6'd0; cmd_op = ~prog[0].op; cmd_slot = prog[0].slot;
        slot_we = 1'b1; slot_idx = prog[0].slot; slot_data = ~slots[prog[0].slot];
        tick();
        cmd_we = 1'b0; slot_we = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        check("post_rst", {opmode, busy, done, step_idx, mismatch, err_count, first_err_idx}, '0);
        check("post_rst_data", input_data, '0);
        play(1, 1'b0, 4);

        // Randomised programs against the window model.
        for (int it = 0; it < 10; it++) begin
            int len, ncyc;
            bit lp;
            for (int i = 0; i < 9; i++) slots[i] = {11{$urandom}};
            clear_prog();
            len = int'($urandom_range(1, 12));
            for (int i = 0; i < len; i++) begin
                prog[i].chk = 1'($urandom);
                prog[i].vc  = int'($urandom_range(0, 4)) - 1;
                prog[i].vc2 = int'($urandom_range(0, 4)) - 1;
                prog[i].vv  = ($urandom_range(0, 2) == 0) ?
                              prog[i].exp ^ (192'd1 << $urandom_range(0, 191)) : prog[i].exp;
                prog[i].vv2 = {6{$urandom}};
            end
            lp   = 1'($urandom);
            ncyc = lp ? int'($urandom_range(3, 3 * len * HOLD)) : len * HOLD;
            load(len);
            play(len, lp, ncyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
